serial_arbiter: RTL and testbench
=================================

SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd12_000_000, meaning: WAIT cycles before abort (1 s at 12 MHz).
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_wr  in  2  per-client write-then-read request pulse, bit i = client i.
REQ-005 req_rd  in  2  per-client read-only request pulse.
REQ-006 req_tx_data  in  16  client i byte in bits [8i+7:8i], sampled with req_wr[i].
REQ-007 req_valid  out  2  one-cycle completion pulse to granted client.
REQ-008 req_rx_data  out  8  received byte, valid while req_valid nonzero, held after.
REQ-009 req_timeout  out  2  one-cycle abort pulse to granted client.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 serial_tx_data  out  8  byte to send/recv engine.
REQ-012 serial_wr  out  1  one-cycle write-then-read command to engine.
REQ-013 serial_rd  out  1  one-cycle read-only command to engine.
REQ-014 serial_valid  in  1  engine completion pulse.
REQ-015 serial_rx_data  in  8  engine received byte, valid with serial_valid.
REQ-016 serial_abort  out  1  one-cycle pulse, ORed into engine reset at top level.

Function
REQ-017 Each client has a pending flag, pending kind (wr/rd) and data register; req_wr[i] or req_rd[i] sets them when not already pending.
REQ-018 req_wr[i] and req_rd[i] together: kind = wr.
REQ-019 Request while pending[i] set: ignored, original request unchanged.
REQ-020 Request on the same cycle its client's pending clears: new request is latched (set beats clear).
REQ-021 FSM states IDLE, ISSUE, WAIT; illegal encoding -> IDLE.
REQ-022 IDLE: any pending -> register grant, go ISSUE; both pending -> round-robin, client other than last_grant wins.
REQ-023 ISSUE: serial_tx_data <= granted data; serial_wr or serial_rd high for exactly one cycle per kind; timer cleared; go WAIT.
REQ-024 Latency: request sampled at cycle N with arbiter idle -> serial_wr/serial_rd high during cycle N+2.
REQ-025 WAIT: serial_valid -> req_rx_data <= serial_rx_data, req_valid[grant] pulses next cycle, pending[grant] cleared, last_grant <= grant, go IDLE.
REQ-026 WAIT: timer increments each cycle; at TIMEOUT-1 without serial_valid -> req_timeout[grant] and serial_abort pulse one cycle, pending[grant] cleared, last_grant <= grant, go IDLE.
REQ-027 serial_valid on the timeout cycle: completion wins, no abort.
REQ-028 serial_valid outside WAIT: ignored.
REQ-029 At most one of serial_wr, serial_rd, req_valid, req_timeout bits high in any cycle.

Reset
REQ-030 Reset: state IDLE, pending and kinds 0, data regs 0, timer 0, last_grant = 1 (client 0 wins first tie).
REQ-031 Reset: every output 0, including req_rx_data and serial_tx_data.
REQ-032 Reset mid-transaction: pending requests discarded, no completion or timeout pulse emitted.

Structure
REQ-033 Shared package serial_arb_pkg: state encodings, NUM_REQ = 2, TIMEOUT default, kind encoding.
REQ-034 Sub-module rr_arbiter2: combinational two-way round-robin select from pending and last_grant.

Verification
REQ-035 Client 0 req_wr, data 8'h41; engine valid with 8'h5A after 10 cycles -> serial_wr at N+2 with tx 8'h41, req_valid=2'b01, req_rx_data=8'h5A.
REQ-036 Both clients req_rd same cycle after reset -> client 0 served first, then client 1; repeat -> client 0 again.
REQ-037 TIMEOUT=16, no serial_valid -> req_timeout[grant] and serial_abort pulse 16 cycles after ISSUE, busy low next cycle.
REQ-038 serial_valid coincident with timeout cycle -> req_valid pulse, no req_timeout, no serial_abort.
REQ-039 Client 1 re-requests on its completion cycle with 8'h33 -> second transaction issued with 8'h33.
REQ-040 Reset asserted during WAIT -> all outputs 0 next cycle, late serial_valid ignored.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg
//   Shared definitions for the serial arbiter: FSM state encoding, request
//   kind encoding, client count and the default WAIT timeout.
package serial_arb_pkg;

  localparam int          NUM_REQ         = 2;
  // 1 s at 12 MHz.
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd12_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Reset value of a kind register is 0, i.e. read-only.
  typedef enum logic {
    KIND_RD = 1'b0,
    KIND_WR = 1'b1
  } kind_t;

endpackage

// File: rtl/serial_arbiter_if.sv
// serial_arbiter_if
//   Command/response bus between the arbiter and the byte send/recv engine.
//   master : arbiter side  (drives serial_tx_data, serial_wr, serial_rd, serial_abort)
//   slave  : engine side   (drives serial_valid, serial_rx_data)
//
// Handshake: there is no ready/backpressure. serial_wr / serial_rd are
// one-cycle command pulses qualified by serial_tx_data in the same cycle;
// the engine answers with a one-cycle serial_valid pulse qualified by
// serial_rx_data. serial_abort is a one-cycle pulse that resets the engine.
interface serial_arbiter_if;
  logic [7:0] serial_tx_data;
  logic       serial_wr;
  logic       serial_rd;
  logic       serial_abort;
  logic       serial_valid;
  logic [7:0] serial_rx_data;

  modport master (
    output serial_tx_data, serial_wr, serial_rd, serial_abort,
    input  serial_valid, serial_rx_data
  );

  modport slave (
    input  serial_tx_data, serial_wr, serial_rd, serial_abort,
    output serial_valid, serial_rx_data
  );
endinterface

// File: rtl/serial_arbiter_rr.sv
// rr_arbiter2
//   Combinational two-way round-robin select.
//   pending     : per-client pending flags
//   last_grant  : client served most recently
//   grant_valid : at least one client pending
//   grant_idx   : selected client; on a tie the client other than last_grant
module rr_arbiter2 (
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);
  always_comb begin
    grant_valid = |pending;
    grant_idx   = 1'b0;
    case (pending)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end
endmodule

// File: rtl/serial_arbiter.sv
// serial_arbiter
//   Shares one serial send/recv engine between two clients. Each client posts
//   a write-then-read (req_wr) or read-only (req_rd) request; the arbiter
//   holds it pending, grants round-robin, issues one engine command and
//   returns either a completion (req_valid + req_rx_data) or, after TIMEOUT
//   WAIT cycles without an answer, an abort (req_timeout + serial_abort).
//
//   clk, reset    : clock, synchronous active-high reset
//   req_wr/req_rd : per-client request pulses (bit i = client i)
//   req_tx_data   : client i byte in [8i+7:8i], sampled with req_wr[i]
//   req_valid     : one-cycle completion pulse to the granted client
//   req_rx_data   : received byte, held until the next completion
//   req_timeout   : one-cycle abort pulse to the granted client
//   busy          : FSM not in IDLE
//   state_dbg     : current FSM state
//   ser           : engine bus (master side)
module serial_arbiter
  import serial_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [NUM_REQ-1:0]   req_rd,
  input  logic [8*NUM_REQ-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]   req_valid,
  output logic [7:0]           req_rx_data,
  output logic [NUM_REQ-1:0]   req_timeout,
  output logic                 busy,
  output state_t               state_dbg,
  serial_arbiter_if.master     ser
);

  state_t             state_q;
  logic [NUM_REQ-1:0] pending_q;
  kind_t              kind_q [NUM_REQ];
  logic [7:0]         data_q [NUM_REQ];
  logic [23:0]        timer_q;
  logic               grant_q;
  logic               last_grant_q;

  logic               arb_valid;
  logic               arb_idx;
  logic               fin_ok;
  logic               fin_to;
  logic [NUM_REQ-1:0] pend_clr;
  logic [NUM_REQ-1:0] new_req;

  rr_arbiter2 u_rr (
    .pending     (pending_q),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // Completion takes priority over a timeout landing on the same cycle.
  always_comb begin
    fin_ok   = (state_q == ST_WAIT) && ser.serial_valid;
    fin_to   = (state_q == ST_WAIT) && !ser.serial_valid &&
               (timer_q == TIMEOUT - 24'd1);
    pend_clr = '0;
    if (fin_ok || fin_to) pend_clr[grant_q] = 1'b1;
    new_req  = req_wr | req_rd;
  end

  // Pending bookkeeping. A request arriving on the cycle its own pending
  // flag clears is latched (set beats clear); otherwise a request against a
  // pending client is dropped so the original request stays intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        kind_q[i] <= KIND_RD;
        data_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (new_req[i] && (!pending_q[i] || pend_clr[i])) begin
          pending_q[i] <= 1'b1;
          kind_q[i]    <= req_wr[i] ? KIND_WR : KIND_RD;
          data_q[i]    <= req_tx_data[8*i +: 8];
        end else if (pend_clr[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // Main FSM. The engine command is registered on the IDLE->ISSUE edge so
  // it is visible during ISSUE, two cycles after the request was sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      timer_q            <= '0;
      grant_q            <= 1'b0;
      last_grant_q       <= 1'b1;
      req_valid          <= '0;
      req_timeout        <= '0;
      req_rx_data        <= 8'h00;
      ser.serial_tx_data <= 8'h00;
      ser.serial_wr      <= 1'b0;
      ser.serial_rd      <= 1'b0;
      ser.serial_abort   <= 1'b0;
    end else begin
      req_valid        <= '0;
      req_timeout      <= '0;
      ser.serial_wr    <= 1'b0;
      ser.serial_rd    <= 1'b0;
      ser.serial_abort <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q            <= arb_idx;
            ser.serial_tx_data <= data_q[arb_idx];
            if (kind_q[arb_idx] == KIND_WR) ser.serial_wr <= 1'b1;
            else                            ser.serial_rd <= 1'b1;
            state_q            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fin_ok) begin
            req_rx_data        <= ser.serial_rx_data;
            req_valid[grant_q] <= 1'b1;
            last_grant_q       <= grant_q;
            state_q            <= ST_IDLE;
          end else if (fin_to) begin
            req_timeout[grant_q] <= 1'b1;
            ser.serial_abort     <= 1'b1;
            last_grant_q         <= grant_q;
            state_q              <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_arbiter.sv
// tb_serial_arbiter
//   Directed and randomized checks of serial_arbiter with TIMEOUT = 16.
//   The bench plays both clients and the serial engine and predicts every
//   grant, command, completion and abort from a transaction-level model.
module tb_serial_arbiter;
  import serial_arb_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_wr, req_rd;
  logic [15:0] req_tx_data;
  logic [1:0]  req_valid, req_timeout;
  logic [7:0]  req_rx_data;
  logic        busy;
  state_t      state_dbg;

  serial_arbiter_if sif ();

  always #5 clk = ~clk;

  serial_arbiter #(.TIMEOUT(24'd16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_wr      (req_wr),
    .req_rd      (req_rd),
    .req_tx_data (req_tx_data),
    .req_valid   (req_valid),
    .req_rx_data (req_rx_data),
    .req_timeout (req_timeout),
    .busy        (busy),
    .state_dbg   (state_dbg),
    .ser         (sif)
  );

  // ---------------- scoreboard / model ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] mdl_pending;
  logic [1:0] mdl_kind;          // 1 = write-then-read
  logic [7:0] mdl_data [2];
  int         mdl_last;
  logic [7:0] mdl_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; command/response pulses
  // must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    check("exclusive", 32'($countones({sif.serial_wr, sif.serial_rd, req_valid, req_timeout}) <= 1), 1);
  endtask

  task automatic model_reset();
    mdl_pending = 2'b00;
    mdl_kind    = 2'b00;
    mdl_data[0] = 8'h00;
    mdl_data[1] = 8'h00;
    mdl_last    = 1;
    mdl_rx      = 8'h00;
  endtask

  task automatic model_accept(input logic [1:0] wr, input logic [1:0] rd, input logic [15:0] data);
    for (int i = 0; i < 2; i++) begin
      if ((wr[i] | rd[i]) && !mdl_pending[i]) begin
        mdl_pending[i] = 1'b1;
        mdl_kind[i]    = wr[i];
        mdl_data[i]    = data[8*i +: 8];
      end
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_valid"},   32'(req_valid),          0);
    check({pfx, "_req_rx_data"}, 32'(req_rx_data),        0);
    check({pfx, "_req_timeout"}, 32'(req_timeout),        0);
    check({pfx, "_busy"},        32'(busy),               0);
    check({pfx, "_tx_data"},     32'(sif.serial_tx_data), 0);
    check({pfx, "_serial_wr"},   32'(sif.serial_wr),      0);
    check({pfx, "_serial_rd"},   32'(sif.serial_rd),      0);
    check({pfx, "_abort"},       32'(sif.serial_abort),   0);
    check({pfx, "_state"},       32'(state_dbg),          32'(ST_IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_wr = '0; req_rd = '0; req_tx_data = '0;
    sif.serial_valid = 1'b0; sif.serial_rx_data = 8'h00;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- driver tasks ----------------
  task automatic post_req(input logic [1:0] wr, input logic [1:0] rd, input logic [15:0] data);
    req_wr = wr; req_rd = rd; req_tx_data = data;
    tick();
    req_wr = '0; req_rd = '0;
    model_accept(wr, rd, data);
  endtask

  // Expect the next grant, answer it in WAIT cycle d (d >= TO means never),
  // optionally injecting a request in WAIT cycle inj_c.
  task automatic serve(input int d, input logic [7:0] rx, input int inj_c,
                       input logic [1:0] inj_wr, input logic [1:0] inj_rd,
                       input logic [15:0] inj_data);
    int         exp_c;
    int         lat;
    logic [1:0] oh;
    bit         fin;
    if (mdl_pending == 2'b11) exp_c = 1 - mdl_last;
    else if (mdl_pending[1])  exp_c = 1;
    else                      exp_c = 0;
    oh  = 2'(1 << exp_c);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(sif.serial_wr || sif.serial_rd) && lat < 8);
    check("issue_latency", 32'(lat),                1);
    check("issue_wr",      32'(sif.serial_wr),      32'(mdl_kind[exp_c]));
    check("issue_rd",      32'(sif.serial_rd),      32'(!mdl_kind[exp_c]));
    check("issue_tx_data", 32'(sif.serial_tx_data), 32'(mdl_data[exp_c]));
    check("issue_busy",    32'(busy),               1);
    tick();
    check("wait0_cmd",  32'({sif.serial_wr, sif.serial_rd}), 0);
    check("wait0_busy", 32'(busy),                           1);
    for (int c = 0; c < TO; c++) begin
      fin = (c == d) || (c == TO - 1);
      if (c == d) begin
        sif.serial_valid = 1'b1; sif.serial_rx_data = rx;
      end
      if (c == inj_c) begin
        req_wr = inj_wr; req_rd = inj_rd; req_tx_data = inj_data;
      end
      tick();
      sif.serial_valid = 1'b0; req_wr = '0; req_rd = '0;
      if (fin) begin
        mdl_pending[exp_c] = 1'b0;
        mdl_last           = exp_c;
      end
      if (c == inj_c) model_accept(inj_wr, inj_rd, inj_data);
      if (c == d) begin
        mdl_rx = rx;
        check("done_valid",   32'(req_valid),        32'(oh));
        check("done_rx_data", 32'(req_rx_data),      32'(rx));
        check("done_timeout", 32'(req_timeout),      0);
        check("done_abort",   32'(sif.serial_abort), 0);
        check("done_busy",    32'(busy),             0);
        break;
      end else if (c == TO - 1) begin
        check("to_timeout", 32'(req_timeout),      32'(oh));
        check("to_abort",   32'(sif.serial_abort), 1);
        check("to_valid",   32'(req_valid),        0);
        check("to_rx_held", 32'(req_rx_data),      32'(mdl_rx));
        check("to_busy",    32'(busy),             0);
        break;
      end else begin
        check("wait_pulses", 32'({req_valid, req_timeout, sif.serial_abort}), 0);
        check("wait_busy",   32'(busy),                                       1);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    req_wr = '0; req_rd = '0; req_tx_data = '0;
    sif.serial_valid = 1'b0; sif.serial_rx_data = 8'h00;
    model_reset();

    // Reset state.
    do_reset();

    // Client 0 write 0x41, engine answers 0x5A ten WAIT cycles later.
    post_req(2'b01, 2'b00, 16'h0041);
    serve(10, 8'h5A, -1, 2'b00, 2'b00, 16'h0000);
    check("d035_rx_held", 32'(req_rx_data), 32'h5A);

    // Simultaneous reads after reset: client 0, then 1; again: client 0 first.
    do_reset();
    post_req(2'b00, 2'b11, 16'h0000);
    serve(3, 8'h10, -1, 2'b00, 2'b00, 16'h0000);
    serve(2, 8'h11, -1, 2'b00, 2'b00, 16'h0000);
    post_req(2'b00, 2'b11, 16'h0000);
    serve(1, 8'h12, -1, 2'b00, 2'b00, 16'h0000);
    serve(0, 8'h13, -1, 2'b00, 2'b00, 16'h0000);

    // No answer: timeout after TO WAIT cycles, idle afterwards.
    post_req(2'b00, 2'b10, 16'h0000);
    serve(1000, 8'h00, -1, 2'b00, 2'b00, 16'h0000);
    tick();
    check("d037_busy_after", 32'(busy), 0);

    // Answer on the last WAIT cycle: completion, no abort.
    post_req(2'b01, 2'b00, 16'h00C3);
    serve(TO - 1, 8'h7E, -1, 2'b00, 2'b00, 16'h0000);

    // Client 1 re-requests on its own completion cycle with 0x33.
    post_req(2'b10, 2'b00, 16'h2200);
    serve(4, 8'h21, 4, 2'b10, 2'b00, 16'h3300);
    check("d039_repending", 32'(mdl_pending), 32'b10);
    serve(2, 8'h34, -1, 2'b00, 2'b00, 16'h0000);

    // Reset in WAIT: outputs clear, late engine answer ignored.
    post_req(2'b01, 2'b00, 16'h0077);
    tick();
    check("d040_issue", 32'(sif.serial_wr), 1);
    tick();
    tick();
    check("d040_in_wait", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check_all_zero("d040_rst");
    reset = 1'b0;
    model_reset();
    sif.serial_valid = 1'b1; sif.serial_rx_data = 8'hEE;
    tick();
    sif.serial_valid = 1'b0;
    check("d040_late_valid", 32'(req_valid),   0);
    check("d040_late_rx",    32'(req_rx_data), 0);
    tick();
    check("d040_no_reissue", 32'({busy, sif.serial_wr, sif.serial_rd}), 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int          d;
      int          ic;
      logic [1:0]  w, r;
      logic [15:0] dat;
      if (mdl_pending == 2'b00) begin
        if ($urandom_range(0, 2) == 0) begin
          sif.serial_valid = 1'b1; sif.serial_rx_data = 8'($urandom);
          tick();
          sif.serial_valid = 1'b0;
          check("idle_valid_ignored", 32'({req_valid, busy}), 0);
          check("idle_rx_held",       32'(req_rx_data),       32'(mdl_rx));
        end
        do begin
          w = 2'($urandom); r = 2'($urandom);
        end while ((w | r) == 2'b00);
        dat = 16'($urandom);
        post_req(w, r, dat);
      end
      d   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 1, TO + 5))
                                        : int'($urandom_range(0, TO - 2));
      ic  = int'($urandom_range(0, TO + 4));
      w   = 2'($urandom); r = 2'($urandom);
      dat = 16'($urandom);
      serve(d, 8'($urandom), ic, w, r, dat);
    end
    for (int k = 0; k < 4 && mdl_pending != 2'b00; k++)
      serve(int'($urandom_range(0, TO + 2)), 8'($urandom), -1, 2'b00, 2'b00, 16'h0000);
    tick();
    check("final_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
